mult_16_seq: RTL

//  Iterative shift-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH product.

---
 rtl/mult_16_seq.sv | 104 ++++++++++
 1 files changed

// File: rtl/mult_16_seq.sv
// mult_16_seq: iterative shift-add unsigned multiplier (WIDTH x WIDTH -> 2*WIDTH).
// The adder is external and shared: this block drives its operands each cycle
// and folds the returned sum/carry back into the accumulator.
module mult_16_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_cout,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Adder operands: high half of the accumulator plus the multiplicand when
    // the current multiplier LSB is set; nothing is added outside RUN.
    always_comb begin
        add_a   = acc_q[2*WIDTH-1:WIDTH];
        add_b   = ((state_q == S_RUN) && acc_q[0]) ? mcand_q : '0;
        add_cin = 1'b0;
    end

    // Next-state logic; busy/done are computed one cycle early so they come
    // straight from flops and line up with the state they describe.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    acc_d   = {{WIDTH{1'b0}}, mplier};
                    mcand_d = mcand;
                    cnt_d   = '0;
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Shift the 2W+1 bit {cout, sum, low} right by one; the carry
                // lands in the MSB so the full (2^W-1)^2 range is kept.
                acc_d = {add_cout, add_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any multiply in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = acc_q;

endmodule
